gtp_frame_rcv: RTL

- Store-and-forward frame receiver for one 16-bit GTP lane, in the 125 MHz GTP clock domain.
- Sits between one lane output of the GTP transceiver block and the receive FIFO.
- Parses SOF/header/payload/checksum framing and forwards only complete frames with a good checksum as a contiguous burst of valid words.
- Bad, truncated and overflowed frames are dropped and counted.

---
 rtl/gtp_frame_rcv_pkg.sv | 39 +++
 rtl/gtp_frame_buf.sv | 38 +++
 rtl/gtp_frame_rcv.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/gtp_frame_rcv_pkg.sv
// Shared definitions for the GTP lane frame receiver.
// Holds the start-of-frame K-word code, header field positions, counter
// indices, the parser state encoding and a saturating increment helper.
package gtp_frame_rcv_pkg;

    localparam logic [7:0] SOF_K_DEF = 8'hFB;

    // Header word layout: [15:12] sequence number, [11:0] payload length
    localparam int SEQ_MSB = 15;
    localparam int SEQ_LSB = 12;
    localparam int LEN_MSB = 11;
    localparam int LEN_LSB = 0;
    localparam int SEQ_W   = SEQ_MSB - SEQ_LSB + 1;
    localparam int LEN_W   = LEN_MSB - LEN_LSB + 1;

    // Buffer word: {eof tag, data}
    localparam int DATA_W  = 16;
    localparam int BUF_W   = DATA_W + 1;

    // Statistics counter slots
    localparam int CNT_FRAMES = 0;
    localparam int CNT_BADSUM = 1;
    localparam int CNT_BADFMT = 2;
    localparam int CNT_SEQ    = 3;
    localparam int CNT_OVF    = 4;
    localparam int NUM_CNT    = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_CSUM = 2'd3
    } state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/gtp_frame_buf.sv
// Simple dual-port packet buffer, one write port and one registered read
// port, written so that synthesis maps it onto block RAM.
// Ports:
//   clk       clock
//   wr_en_i   write strobe
//   wr_addr_i write address
//   wr_data_i write word ({eof, data})
//   rd_en_i   read strobe
//   rd_addr_i read address
//   rd_data_o read word, valid the cycle after rd_en_i
module gtp_frame_buf #(
    parameter int AW = 10,
    parameter int DW = 17
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en_i) begin
            rd_data_o <= mem[rd_addr_i];
        end
    end

endmodule

// File: rtl/gtp_frame_rcv.sv
// Store-and-forward frame receiver for one 16-bit GTP lane.
// Parses SOF / header / payload / checksum, buffers the frame, and only
// releases it to the output once the checksum has been verified. Bad,
// truncated and overflowed frames are rolled back and counted.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   gtp_dat, gtp_kchar  lane data and K-word flag
//   out_dat/vld/eof     forwarded words (header then payload), eof on last
//   cnt_clr             clears all statistics counters
//   cnt_*               saturating 16-bit statistics
//   buf_level           committed words not yet drained
module gtp_frame_rcv
    import gtp_frame_rcv_pkg::*;
#(
    parameter int         AW      = 10,
    parameter int         MAX_LEN = 255,
    parameter logic [7:0] SOF_K   = SOF_K_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] gtp_dat,
    input  logic        gtp_kchar,
    output logic [15:0] out_dat,
    output logic        out_vld,
    output logic        out_eof,
    input  logic        cnt_clr,
    output logic [15:0] cnt_frames,
    output logic [15:0] cnt_badsum,
    output logic [15:0] cnt_badfmt,
    output logic [15:0] cnt_seq,
    output logic [15:0] cnt_ovf,
    output logic [AW:0] buf_level
);

    localparam logic [AW:0]      DEPTH     = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]      PTR_ONE   = 1;
    localparam logic [LEN_W-1:0] LEN_ONE   = 1;
    localparam logic [LEN_W-1:0] MAX_LEN_W = LEN_W'(MAX_LEN);

    state_t             state_q;
    logic [AW:0]        wr_ptr_q, cmt_ptr_q, rd_ptr_q;
    logic [15:0]        sum_q;
    logic [LEN_W-1:0]   remain_q;
    logic [SEQ_W-1:0]   seq_q, exp_seq_q;
    logic               seq_seen_q;
    logic               ovf_q;
    logic               rd_vld_q;
    logic [15:0]        out_dat_q;
    logic               out_vld_q, out_eof_q;

    logic               is_sof, len_ok, buf_full;
    logic [LEN_W-1:0]   hdr_len;
    logic [SEQ_W-1:0]   hdr_seq;
    logic               wr_req, wr_eof, wr_en, ovf_now, rd_en;
    logic               ev_badfmt, ev_badsum, ev_ovf, commit, drop, seq_err;
    logic [BUF_W-1:0]   rd_data;
    logic [NUM_CNT-1:0] cnt_ev;
    logic [NUM_CNT-1:0][15:0] cnt_all;

    assign is_sof   = gtp_kchar && (gtp_dat[7:0] == SOF_K);
    assign hdr_len  = gtp_dat[LEN_MSB:LEN_LSB];
    assign hdr_seq  = gtp_dat[SEQ_MSB:SEQ_LSB];
    assign len_ok   = (hdr_len != '0) && (hdr_len <= MAX_LEN_W);
    // Fullness is judged against the read pointer, so draining frees room
    // for the frame currently being written.
    assign buf_full = (wr_ptr_q - rd_ptr_q) == DEPTH;

    // Per-word decode of what the current input does to the frame
    always_comb begin
        wr_req    = 1'b0;
        wr_eof    = 1'b0;
        ev_badfmt = 1'b0;
        ev_badsum = 1'b0;
        ev_ovf    = 1'b0;
        commit    = 1'b0;
        drop      = 1'b0;
        unique case (state_q)
            ST_HDR: begin
                if (gtp_kchar || !len_ok) ev_badfmt = 1'b1;
                else                      wr_req    = 1'b1;
            end
            ST_DATA: begin
                if (gtp_kchar) begin
                    ev_badfmt = 1'b1;
                    drop      = 1'b1;
                end else begin
                    wr_req = 1'b1;
                    wr_eof = (remain_q == LEN_ONE);
                end
            end
            ST_CSUM: begin
                if (gtp_kchar) begin
                    ev_badfmt = 1'b1;
                    drop      = 1'b1;
                end else if (ovf_q) begin
                    // overflow wins over a checksum verdict
                    ev_ovf = 1'b1;
                    drop   = 1'b1;
                end else if (gtp_dat == sum_q) begin
                    commit = 1'b1;
                end else begin
                    ev_badsum = 1'b1;
                    drop      = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Once a frame overflows, every later word of it is discarded too.
    // ovf_q still holds the previous frame's flag while in HDR, so ignore it.
    assign ovf_now = wr_req && (buf_full || (ovf_q && state_q == ST_DATA));
    assign wr_en   = wr_req && !ovf_now;
    assign seq_err = commit && seq_seen_q && (seq_q != exp_seq_q);

    // Parser FSM and write-side pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            cmt_ptr_q  <= '0;
            sum_q      <= '0;
            remain_q   <= '0;
            seq_q      <= '0;
            exp_seq_q  <= '0;
            seq_seen_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            if (wr_en)  wr_ptr_q <= wr_ptr_q + PTR_ONE;
            // commit/drop only happen in cycles without a write
            if (drop)   wr_ptr_q <= cmt_ptr_q;
            if (commit) begin
                cmt_ptr_q  <= wr_ptr_q;
                exp_seq_q  <= seq_q + SEQ_W'(1);
                seq_seen_q <= 1'b1;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (is_sof) state_q <= ST_HDR;
                end
                ST_HDR: begin
                    if (ev_badfmt) begin
                        state_q <= is_sof ? ST_HDR : ST_IDLE;
                    end else begin
                        sum_q    <= gtp_dat;
                        remain_q <= hdr_len;
                        seq_q    <= hdr_seq;
                        ovf_q    <= ovf_now;
                        state_q  <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (gtp_kchar) begin
                        state_q <= is_sof ? ST_HDR : ST_IDLE;
                    end else begin
                        sum_q    <= sum_q + gtp_dat;
                        remain_q <= remain_q - LEN_ONE;
                        if (ovf_now)              ovf_q   <= 1'b1;
                        if (remain_q == LEN_ONE)  state_q <= ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    state_q <= is_sof ? ST_HDR : ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    gtp_frame_buf #(
        .AW (AW),
        .DW (BUF_W)
    ) u_buf (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_ptr_q[AW-1:0]),
        .wr_data_i ({wr_eof, gtp_dat}),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_ptr_q[AW-1:0]),
        .rd_data_o (rd_data)
    );

    // Drain: RAM read stage, then output register
    assign rd_en = (rd_ptr_q != cmt_ptr_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q  <= '0;
            rd_vld_q  <= 1'b0;
            out_vld_q <= 1'b0;
            out_eof_q <= 1'b0;
            out_dat_q <= '0;
        end else begin
            if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_ONE;
            rd_vld_q  <= rd_en;
            out_vld_q <= rd_vld_q;
            out_eof_q <= rd_vld_q && rd_data[DATA_W];
            out_dat_q <= rd_vld_q ? rd_data[DATA_W-1:0] : '0;
        end
    end

    assign out_dat   = out_dat_q;
    assign out_vld   = out_vld_q;
    assign out_eof   = out_eof_q;
    assign buf_level = cmt_ptr_q - rd_ptr_q;

    // Statistics counters; clear beats a same-cycle increment
    assign cnt_ev[CNT_FRAMES] = commit;
    assign cnt_ev[CNT_BADSUM] = ev_badsum;
    assign cnt_ev[CNT_BADFMT] = ev_badfmt;
    assign cnt_ev[CNT_SEQ]    = seq_err;
    assign cnt_ev[CNT_OVF]    = ev_ovf;

    for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
        logic [15:0] cnt_q;
        always_ff @(posedge clk) begin
            if (rst || cnt_clr)  cnt_q <= '0;
            else if (cnt_ev[gi]) cnt_q <= sat_inc(cnt_q);
        end
        assign cnt_all[gi] = cnt_q;
    end

    assign cnt_frames = cnt_all[CNT_FRAMES];
    assign cnt_badsum = cnt_all[CNT_BADSUM];
    assign cnt_badfmt = cnt_all[CNT_BADFMT];
    assign cnt_seq    = cnt_all[CNT_SEQ];
    assign cnt_ovf    = cnt_all[CNT_OVF];

endmodule
